// File: rtl/ysyx_23060236_lsu_split.sv
// ysyx_23060236_lsu_split: AXI-lite load/store unit, optional misaligned split via YSYX_23060236_LSU_MISALIGN_SPLIT_EN
module ysyx_23060236_lsu_split #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W-1:0]   in_wb_val,
  input  logic [2:0]          in_funct3,
  input  logic                in_ren,
  input  logic                in_wen,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_fault,
  output logic [1:0]          out_cause,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  output logic [2:0]          arsize,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  output logic [2:0]          awsize,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  localparam int NB = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_RESP = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]          state_q, state_d;
  logic                beat_q, beat_d;
  logic                aw_ok_q, aw_ok_d;
  logic                w_ok_q, w_ok_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
  logic [DATA_W-1:0]   od_q, od_d;
  logic [2:0]          f3_q, f3_d;
  logic                of_q, of_d;
  logic [1:0]          oc_q, oc_d;

  logic [OFFW-1:0]     off;
  logic [3:0]          sz;
  logic [6:0]          szb;
  logic                split, mis_bad, bad_size, sgn;
  logic [ADDR_W-1:0]   beat_addr;
  logic [2:0]          xsize;
  logic [DATA_W-1:0]   m, ext_mask, rd_ext;
  logic [2*DATA_W-1:0] wfull;
  logic [2*NB-1:0]     mfull;

  assign off = addr_q[OFFW-1:0];
  assign sz = 4'd1 << f3_q[1:0];
  assign szb = 7'd8 << f3_q[1:0];
  assign bad_size = (DATA_W == 32) && (in_funct3[1:0] == 2'd3 || in_funct3 == 3'b110);

`ifdef YSYX_23060236_LSU_MISALIGN_SPLIT_EN
  assign split = (int'(off) + int'(sz)) > NB;
  assign mis_bad = 1'b0;
`else
  assign split = 1'b0;
  assign mis_bad = (in_funct3[1:0] == 2'd1 && in_addr[0]) ||
                   (in_funct3[1:0] == 2'd2 && |in_addr[1:0]) ||
                   (in_funct3[1:0] == 2'd3 && |in_addr[2:0]);
`endif

  assign beat_addr = split ? ({addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} + (beat_q ? ADDR_W'(NB) : '0)) : addr_q;
  assign xsize = split ? 3'(OFFW) : {1'b0, f3_q[1:0]};
  assign araddr = beat_addr;
  assign awaddr = beat_addr;
  assign arsize = xsize;
  assign awsize = xsize;
  assign in_ready = state_q == S_IDLE;
  assign arvalid = state_q == S_RD_REQ;
  assign rready = state_q == S_RD_RESP;
  assign awvalid = state_q == S_WR_REQ && !aw_ok_q;
  assign wvalid = state_q == S_WR_REQ && !w_ok_q;
  assign bready = state_q == S_WR_RESP;
  assign out_valid = state_q == S_DONE;
  assign out_data = od_q;
  assign out_fault = of_q;
  assign out_cause = oc_q;

  assign m = DATA_W'({(split ? rdata : {DATA_W{1'b0}}), (split ? buf0_q : rdata)} >> {off, 3'b000});
  assign sgn = ~f3_q[2] & (f3_q[1:0] == 2'd0 ? m[7] : f3_q[1:0] == 2'd1 ? m[15] : f3_q[1:0] == 2'd2 ? m[31] : m[DATA_W-1]);
  assign ext_mask = ~({DATA_W{1'b1}} << szb);
  assign rd_ext = (m & ext_mask) | ({DATA_W{sgn}} & ~ext_mask);
  assign wfull = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
  assign mfull = ~({(2*NB){1'b1}} << sz) << off;
  assign wdata = beat_q ? wfull[2*DATA_W-1:DATA_W] : wfull[DATA_W-1:0];
  assign wstrb = beat_q ? mfull[2*NB-1:NB] : mfull[NB-1:0];

  // next-state and result computation for the one access in flight
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    aw_ok_d = aw_ok_q;
    w_ok_d = w_ok_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    buf0_d = buf0_q;
    f3_d = f3_q;
    od_d = od_q;
    of_d = of_q;
    oc_d = oc_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        addr_d = in_addr;
        wdata_d = in_wdata;
        f3_d = in_funct3;
        beat_d = 1'b0;
        aw_ok_d = 1'b0;
        w_ok_d = 1'b0;
        od_d = '0;
        of_d = 1'b1;
        state_d = S_DONE;
        if (in_ren && in_wen) oc_d = 2'b11;
        else if (!in_ren && !in_wen) begin
          of_d = 1'b0;
          oc_d = 2'b00;
          od_d = in_wb_val;
        end else if (bad_size || mis_bad) oc_d = 2'b01;
        else begin
          of_d = 1'b0;
          oc_d = 2'b00;
          state_d = in_ren ? S_RD_REQ : S_WR_REQ;
        end
      end
      S_RD_REQ: if (arready) state_d = S_RD_RESP;
      S_RD_RESP: if (rvalid) begin
        if (rresp != 2'b00) begin
          state_d = S_DONE;
          of_d = 1'b1;
          oc_d = 2'b10;
          od_d = '0;
        end else if (split && !beat_q) begin
          buf0_d = rdata;
          beat_d = 1'b1;
          state_d = S_RD_REQ;
        end else begin
          state_d = S_DONE;
          od_d = rd_ext;
        end
      end
      S_WR_REQ: begin
        aw_ok_d = aw_ok_q | awready;
        w_ok_d = w_ok_q | wready;
        if (aw_ok_d && w_ok_d) begin
          state_d = S_WR_RESP;
          aw_ok_d = 1'b0;
          w_ok_d = 1'b0;
        end
      end
      S_WR_RESP: if (bvalid) begin
        if (bresp != 2'b00) begin
          state_d = S_DONE;
          of_d = 1'b1;
          oc_d = 2'b10;
        end else if (split && !beat_q) begin
          beat_d = 1'b1;
          state_d = S_WR_REQ;
        end else state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; reset abandons any access in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q <= 1'b0;
      aw_ok_q <= 1'b0;
      w_ok_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      buf0_q <= '0;
      f3_q <= '0;
      od_q <= '0;
      of_q <= 1'b0;
      oc_q <= 2'b00;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q <= w_ok_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      buf0_q <= buf0_d;
      f3_q <= f3_d;
      od_q <= od_d;
      of_q <= of_d;
      oc_q <= oc_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060236_lsu_split.sv
// tb_ysyx_23060236_lsu_split: random and directed checks of the LSU against a byte-memory reference model
module tb_ysyx_23060236_lsu_split;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_ready, in_ren = 1'b0, in_wen = 1'b0;
  logic [31:0] in_addr = '0, in_wdata = '0, in_wb_val = '0;
  logic [2:0] in_funct3 = '0;
  logic out_valid, out_ready = 1'b0, out_fault;
  logic [31:0] out_data;
  logic [1:0] out_cause;
  logic [31:0] araddr, awaddr, wdata;
  logic [31:0] rdata = '0;
  logic [2:0] arsize, awsize;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic bvalid = 1'b0, bready;
  logic [1:0] rresp = '0, bresp = '0;
  logic [3:0] wstrb;

  ysyx_23060236_lsu_split #(.DATA_W(32), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_wb_val(in_wb_val), .in_funct3(in_funct3), .in_ren(in_ren), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fault(out_fault), .out_cause(out_cause),
    .araddr(araddr), .arvalid(arvalid), .arsize(arsize), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awsize(awsize), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

`ifdef YSYX_23060236_LSU_MISALIGN_SPLIT_EN
  localparam int MIS_CAUSE = 0;
`else
  localparam int MIS_CAUSE = 1;
`endif

  int n_assert = 0, n_fail = 0;
  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:255];
  int ar_dly, r_dly, aw_dly, w_dly, b_dly, o_dly, err_beat;
  int lat, ar_cnt, aw_cnt, w_cnt, b_cnt;
  logic [31:0] got_data, ar_a0, ar_a1, aw_a0, w_d0;
  logic got_fault;
  logic [1:0] got_cause;
  logic [2:0] ar_s0;
  logic [3:0] w_s0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_dly(input int d);
    ar_dly = d; r_dly = d; aw_dly = d; w_dly = d; b_dly = d; o_dly = d; err_beat = -1;
  endtask

  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      mem[a + 8'(k)] = v[8*k +: 8];
      ref_mem[a + 8'(k)] = v[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    longint v = 0;
    int sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) v = v | (longint'(ref_mem[8'(a + 32'(i))]) << (8 * i));
    if (!f3[2] && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // Drives one request and plays the AXI-lite slave and WBU until the result is taken
  task automatic run_op(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wb);
    int ar_w, r_w, aw_w, w_w, b_w, o_w, r_beat;
    logic r_pend, aw_got, w_got, seen, done;
    logic [31:0] r_a, aw_a, w_d;
    logic [3:0] w_s;
    logic [7:0] base;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0; o_w = 0; r_beat = 0;
    r_pend = 0; aw_got = 0; w_got = 0; seen = 0; done = 0;
    r_a = '0; aw_a = '0; w_d = '0; w_s = '0;
    lat = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_ren = ren; in_wen = wen; in_funct3 = f3; in_addr = a; in_wdata = wd; in_wb_val = wb;
    @(negedge clock);
    in_valid = 0;
    for (int c = 1; c < 300 && !done; c++) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; out_ready = 0; rresp = 0; bresp = 0;
      if (out_valid) begin
        if (!seen) begin
          seen = 1; lat = c; got_data = out_data; got_fault = out_fault; got_cause = out_cause;
        end else chk("out_stable", {out_data, out_fault, out_cause}, {got_data, got_fault, got_cause});
        chk("in_ready_busy", in_ready, 0);
        if (o_w >= o_dly) begin out_ready = 1; done = 1; end else o_w++;
      end
      if (r_pend && rready) begin
        if (r_w >= r_dly) begin
          base = {r_a[7:2], 2'b00};
          rvalid = 1;
          rdata = {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
          rresp = (r_beat == err_beat) ? 2'b10 : 2'b00;
          r_pend = 0; r_beat++; r_w = 0;
        end else r_w++;
      end
      if (arvalid) begin
        if (ar_w >= ar_dly) begin
          arready = 1;
          if (ar_cnt == 0) begin ar_a0 = araddr; ar_s0 = arsize; end else ar_a1 = araddr;
          ar_cnt++; r_pend = 1; r_a = araddr; r_w = 0; ar_w = 0;
        end else ar_w++;
      end
      if (bready && aw_got && w_got) begin
        if (b_w >= b_dly) begin
          bvalid = 1;
          base = {aw_a[7:2], 2'b00};
          for (int k = 0; k < 4; k++) if (w_s[k]) mem[base + 8'(k)] = w_d[8*k +: 8];
          aw_got = 0; w_got = 0; b_cnt++; b_w = 0;
        end else b_w++;
      end
      if (awvalid) begin
        if (aw_w >= aw_dly) begin
          awready = 1;
          if (aw_cnt == 0) aw_a0 = awaddr;
          aw_cnt++; aw_a = awaddr; aw_got = 1; aw_w = 0;
        end else aw_w++;
      end
      if (wvalid) begin
        if (w_w >= w_dly) begin
          wready = 1;
          if (w_cnt == 0) begin w_d0 = wdata; w_s0 = wstrb; end
          w_cnt++; w_d = wdata; w_s = wstrb; w_got = 1; w_w = 0;
        end else w_w++;
      end
      @(negedge clock);
    end
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; out_ready = 0;
    chk("timeout", done, 1);
    if (done) chk("in_ready_after", in_ready, 1);
  endtask

  // Runs one operation and compares everything observable with the reference rules
  task automatic do_op(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wb, input int exp_lat);
    int sz, cause, nb, bad;
    sz = 1 << f3[1:0];
    cause = (ren && wen) ? 3 : (!ren && !wen) ? 0 : (f3[1:0] == 2'd3 || f3 == 3'b110) ? 1 :
            (a % 32'(sz) != 0) ? MIS_CAUSE : 0;
    nb = (cause != 0 || (!ren && !wen)) ? 0 : ((int'(a % 4) + sz > 4) ? 2 : 1);
    if (ren && !wen && err_beat >= 0 && err_beat < nb) begin cause = 2; nb = err_beat + 1; end
    run_op(ren, wen, f3, a, wd, wb);
    chk("fault", got_fault, cause != 0);
    chk("cause", got_cause, cause);
    chk("ar_count", ar_cnt, (ren && !wen) ? nb : 0);
    chk("aw_count", aw_cnt, (wen && !ren) ? nb : 0);
    chk("b_count", b_cnt, (wen && !ren) ? nb : 0);
    if (cause == 0 && ren) chk("load_data", got_data, model_load(a, f3));
    if (!ren && !wen) chk("pass_data", got_data, wb);
    if (cause == 0 && wen && !ren) begin
      for (int i = 0; i < sz; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("store_mem", bad, 0);
    end
    if (exp_lat > 0) chk("latency", lat, exp_lat);
  endtask

  initial begin
    logic [7:0] v;
    int r;
    logic rn, wn;
    for (int i = 0; i < 256; i++) begin v = 8'($urandom); mem[i] = v; ref_mem[i] = v; end
    set_dly(0);
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, out_valid}, 0);
    chk("rst_out", {out_data, out_fault, out_cause}, 0);
    reset = 1;
    @(negedge clock);

    set_word(8'h04, 32'hDEADBEEF);
    do_op(1, 0, 3'b010, 32'h80000004, 0, 0, 3);
    chk("lw_data", got_data, 32'hDEADBEEF);
    chk("lw_araddr", ar_a0, 32'h80000004);
    chk("lw_arsize", ar_s0, 3'd2);

    set_word(8'h00, 32'h80112233);
    do_op(1, 0, 3'b000, 32'h80000003, 0, 0, 3);
    chk("lb_data", got_data, 32'hFFFFFF80);
    chk("lb_araddr", ar_a0, 32'h80000003);
    chk("lb_arsize", ar_s0, 3'd0);
    do_op(1, 0, 3'b100, 32'h80000003, 0, 0, 3);
    chk("lbu_data", got_data, 32'h00000080);

    aw_dly = 3;
    do_op(0, 1, 3'b001, 32'h10000002, 32'h0000ABCD, 0, 0);
    chk("sh_wdata", w_d0, 32'hABCD0000);
    chk("sh_wstrb", w_s0, 4'b1100);
    chk("sh_awaddr", aw_a0, 32'h10000002);
    chk("sh_bresp_once", b_cnt, 1);
    aw_dly = 0;

    set_word(8'h00, 32'h44332211);
    set_word(8'h04, 32'h88776655);
    do_op(1, 0, 3'b010, 32'h80000003, 0, 0, 0);
`ifdef YSYX_23060236_LSU_MISALIGN_SPLIT_EN
    chk("split_data", got_data, 32'h77665544);
    chk("split_ar0", ar_a0, 32'h80000000);
    chk("split_ar1", ar_a1, 32'h80000004);
`else
    chk("mis_cause", got_cause, 2'b01);
    chk("mis_no_ar", ar_cnt, 0);
`endif

    err_beat = 0;
    do_op(1, 0, 3'b010, 32'h80000008, 0, 0, 0);
    chk("err_cause", got_cause, 2'b10);
    err_beat = -1;

    o_dly = 5;
    do_op(1, 0, 3'b001, 32'h80000006, 0, 0, 0);
    o_dly = 0;

    do_op(0, 0, 3'b010, 32'h80000000, 0, 32'h12345678, 1);
    do_op(1, 1, 3'b010, 32'h80000000, 0, 0, 1);
    do_op(1, 0, 3'b011, 32'h80000000, 0, 0, 1);

    in_valid = 1; in_ren = 1; in_wen = 0; in_funct3 = 3'b010; in_addr = 32'h80000010;
    @(negedge clock);
    in_valid = 0; arready = 1;
    @(negedge clock);
    chk("mid_rready", rready, 1);
    arready = 0; rvalid = 1; rdata = 32'hCAFEF00D; rresp = 0; reset = 0;
    @(negedge clock);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valids", {arvalid, awvalid, wvalid, rready, bready, out_valid}, 0);
    reset = 1; rvalid = 0;
    @(negedge clock);
    do_op(1, 0, 3'b010, 32'h80000010, 0, 0, 3);

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      rn = r < 5 || (r == 9 && $urandom_range(0, 1) == 1);
      wn = (r >= 5 && r < 9) || (r == 9 && rn);
      ar_dly = int'($urandom_range(0, 2)); r_dly = int'($urandom_range(0, 2));
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      b_dly = int'($urandom_range(0, 2)); o_dly = int'($urandom_range(0, 2));
      err_beat = (rn && !wn && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
      do_op(rn, wn, 3'($urandom_range(0, 7)), 32'h80000000 | 32'($urandom_range(0, 255)),
            $urandom, $urandom, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
